// File: rtl/dflipflop_fall_syn_if.sv
// dflipflop_fall_syn_if: data/output bundle of the falling-edge flip-flop
interface dflipflop_fall_syn_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  modport master (output d, input q, input q_bar);
  modport slave (input d, output q, output q_bar);
endinterface

// File: rtl/dflipflop_fall_syn.sv
// dflipflop_fall_syn: falling-edge D flip-flop, sync active-low reset, true/complement outputs; DFF_FALL_XCHECK_EN adds sim-only X checks
module dflipflop_fall_syn_core #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic clk,
  input logic reset,
  dflipflop_fall_syn_if.slave bus
);
  logic [WIDTH-1:0] q_d, q_q;
`ifdef DFF_FALL_XCHECK_EN
  logic rst_seen_d, rst_seen_q;
  // next state: unknown reset, or unknown d while out of reset, poisons q
  always_comb
    q_d = ($isunknown(reset) || (reset === 1'b1 && $isunknown(bus.d))) ? {WIDTH{1'bx}} :
          !reset ? RESET_VALUE : bus.d;
  // remembers that a known reset has been seen so later X on q is suspicious
  always_comb rst_seen_d = rst_seen_q | (reset === 1'b0);
  // report X/Z inputs at the capturing edge and X on q after a clean reset
  always_ff @(negedge clk) begin
    if ($isunknown(reset)) $error("dflipflop_fall_syn: reset is X/Z at %0t", $time);
    else if (reset && $isunknown(bus.d)) $error("dflipflop_fall_syn: d is X/Z at %0t", $time);
    if (rst_seen_q === 1'b1 && $isunknown(q_q)) $warning("dflipflop_fall_syn: q is X at %0t", $time);
    rst_seen_q <= rst_seen_d;
  end
`else
  // next state: reset has priority over d
  always_comb q_d = !reset ? RESET_VALUE : bus.d;
`endif
  // the only storage element, updated on the falling edge alone
  always_ff @(negedge clk) q_q <= q_d;
  assign bus.q = q_q;
  assign bus.q_bar = ~q_q;
endmodule

module dflipflop_fall_syn #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             reset
);
  dflipflop_fall_syn_if #(.WIDTH(WIDTH)) bus ();
  assign bus.d = d;
  assign q = bus.q;
  assign q_bar = bus.q_bar;
  dflipflop_fall_syn_core #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_core (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
endmodule

// File: tb/tb_dflipflop_fall_syn.sv
// tb_dflipflop_fall_syn: directed vectors for 1-bit and 8-bit (reset A5) flip-flops
module tb_dflipflop_fall_syn;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  dflipflop_fall_syn_if #(.WIDTH(1)) b1 ();
  dflipflop_fall_syn_if #(.WIDTH(8)) b8 ();
  dflipflop_fall_syn u1 (
    .q(b1.q), .q_bar(b1.q_bar), .d(b1.d), .clk(clk), .reset(reset)
  );
  dflipflop_fall_syn #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
    .q(b8.q), .q_bar(b8.q_bar), .d(b8.d), .clk(clk), .reset(reset)
  );
  always #10 clk = ~clk;
  typedef struct {
    logic       rst;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string name, input logic q1, input logic [7:0] q8);
    chk({name, " q1"}, {63'd0, b1.q}, {63'd0, q1});
    chk({name, " q_bar1"}, {63'd0, b1.q_bar}, {63'd0, ~q1});
    chk({name, " q8"}, {56'd0, b8.q}, {56'd0, q8});
    chk({name, " q_bar8"}, {56'd0, b8.q_bar}, {56'd0, ~q8});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    b1.d = 1'b0;
    b8.d = 8'h00;
    vecs[0] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 8'hC3, 1'b0, 8'hC3};
    vecs[3] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 1'b0, 8'hFF};
    vecs[6] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #2;
      reset = vecs[i].rst;
      b1.d = vecs[i].d1;
      b8.d = vecs[i].d8;
      @(negedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].q1, vecs[i].q8);
    end
    b1.d = 1'b0;
    b8.d = 8'h77;
    @(posedge clk);
    #1;
    chk_all("rise_no_effect", 1'b1, 8'h5A);
    @(negedge clk);
    #1;
    chk_all("capture_after_hold", 1'b0, 8'h77);
    b1.d = 1'b1;
    @(negedge clk);
    #1;
    chk("capture_one q1", {63'd0, b1.q}, 64'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #3;
    chk_all("reset_not_async", 1'b1, 8'h77);
    @(negedge clk);
    #1;
    chk_all("reset_at_fall", 1'b0, 8'hA5);
    reset = 1'b1;
    b1.d = 1'b0;
    b8.d = 8'h0F;
    @(negedge clk);
    #1;
    chk_all("release", 1'b0, 8'h0F);
    @(posedge clk);
    #2;
    b1.d = 1'b1;
    b8.d = 8'hF0;
    #2;
    b1.d = 1'b0;
    b8.d = 8'h0F;
    #2;
    b1.d = 1'b1;
    #2;
    b1.d = 1'b0;
    @(negedge clk);
    #1;
    chk_all("d_glitch", 1'b0, 8'h0F);
    b1.d = 1'b1;
    b8.d = 8'h3C;
    @(negedge clk);
    #1;
    chk_all("pre_rst_glitch", 1'b1, 8'h3C);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #3;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_all("rst_glitch", 1'b1, 8'h3C);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dflipflop_fall_syn.md
Name: dflipflop_fall_syn

Overview:
- Falling-edge-triggered D flip-flop with synchronous, active-low reset.
- Provides true and complementary outputs.
- Generic storage/retiming primitive for negative-edge pipeline stages and logic-lab style sequential datapaths.
- Width is parameterisable; the default is a single bit.

Parameters:
- WIDTH, 1, bit width of d, q and q_bar; legal range 1..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on a falling clock edge while reset is asserted.

Ports:
- clk  input  1  clock; all state changes occur on the falling edge only.
- reset  input  1  synchronous active-low reset; 0 = reset asserted; sampled on the falling edge of clk.
- q  output  WIDTH  registered data output.
- q_bar  output  WIDTH  bitwise complement of q.
- d  input  WIDTH  data input, sampled on the falling edge of clk.
- Positional instantiation order is fixed: (q, q_bar, d, clk, reset).

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-low (reset = 0 asserts reset).
- Falling-edge rules on clk (1->0):
  - reset == 0: q <= RESET_VALUE; d is ignored.
  - reset == 1: q <= d.
- Rising edges of clk have no effect on q.
- Changes on d or reset between falling edges have no effect on q.
- Reset is not asynchronous. Asserting or deasserting reset while clk is high or low changes nothing until the next falling edge.
- q_bar = ~q at all times. It is combinational from the register and changes in the same delta as q; no separate register.
- Latency: d to q is one falling edge. The new q is visible immediately after the capturing edge and is held until the next falling edge.
- Power-up: q is undefined (X in simulation) until the first falling edge. No initial block. A falling edge with reset == 0 establishes RESET_VALUE.
- Reset takes priority over d.
- d changing exactly at the falling edge: the value present at the edge is captured (standard setup/hold semantics). Benches change d away from falling edges.
- Reset deasserting at the same edge it is sampled: the sampled value governs that edge. Sampled 0 means reset; sampled 1 means capture d.
- Outputs are never tri-stated.
- No enable and no set input.

Optional Feature:
- Macro: DFF_FALL_XCHECK_EN.
- When defined, simulation-only checking is compiled in. At every falling edge, if d (with reset == 1) or reset contains X/Z:
  - q is driven to all-X.
  - A $error is issued naming the offending signal and $time.
- When defined, a $warning is also issued if q is read as X after the first falling edge with a known reset == 0.
- When undefined, no checks are compiled. Standard Verilog X-propagation of the register applies. Synthesised netlist identical either way.

Test Plan:
- Synchronous reset: reset=0, d=1, clk falls at t=20 -> q=0, q_bar=1. No change to q at the t=10 rising edge.
- Reset is not asynchronous: q=1 (captured earlier), then reset=0 driven while clk=1 -> q stays 1 until the next falling edge, then q=0, q_bar=1.
- Capture: reset=1, d=1, clk falls -> q=1, q_bar=0. Then d=0, clk rises -> q stays 1. Next clk fall -> q=0, q_bar=1.
- Edge sensitivity: reset=1, toggle d 0->1->0 entirely while clk is high, d=0 at the falling edge -> q=0. Glitches on d are not captured.
- Reset priority: reset=0 and d=1 at the same falling edge -> q=RESET_VALUE (0). Release reset=1 with d=1, next fall -> q=1.
- Parameterised: WIDTH=8, RESET_VALUE=8'hA5:
  - reset=0, fall -> q=8'hA5, q_bar=8'h5A.
  - reset=1, d=8'h3C, fall -> q=8'h3C, q_bar=8'hC3.
  - With DFF_FALL_XCHECK_EN defined, d=8'bx at a fall -> $error reported, q=X.
